// File: rtl/ocidec1_wb_slave_pkg.sv
// Shared definitions for the OCIDEC-1 host bus stage: register map, bit positions,
// revision code and PIO request state encoding.
package ocidec1_wb_slave_pkg;

  localparam logic [3:0] ADR_CTRL = 4'd0;
  localparam logic [3:0] ADR_STAT = 4'd1;
  localparam logic [3:0] ADR_PCTR = 4'd2;

  localparam int unsigned CTRL_RST     = 0;
  localparam int unsigned CTRL_IDEEN   = 1;
  localparam int unsigned CTRL_IORDYEN = 2;
  localparam int unsigned CTRL_IEN     = 3;

  localparam int unsigned STAT_IRQ  = 0;
  localparam int unsigned STAT_BUSY = 7;

  localparam logic [7:0] REVISION = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIO,
    ST_DONE
  } pio_state_e;

endpackage

// File: rtl/ocidec1_wb_slave_if.sv
// Wishbone classic bus bundle between the host and the OCIDEC-1 register stage.
interface ocidec1_wb_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_inta_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_inta_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_inta_o
  );
endinterface

// File: rtl/ocidec1_wb_slave.sv
// OCIDEC-1 host register stage: CTRL/STAT/PCTR register file plus a single-request
// PIO handshake engine for accesses to the ATA register window.
module ocidec1_wb_slave
  import ocidec1_wb_slave_pkg::*;
#(
  parameter int unsigned TWIDTH         = 8,
  parameter int unsigned PIO_mode0_T1   = 6,
  parameter int unsigned PIO_mode0_T2   = 28,
  parameter int unsigned PIO_mode0_T4   = 2,
  parameter int unsigned PIO_mode0_Teoc = 23
) (
  input  logic              clk,
  input  logic              rst,
  ocidec1_wb_slave_if.slave wb,
  input  logic              irq,
  output logic              IDEctrl_rst,
  output logic              IDEctrl_IDEen,
  output logic              PIO_cmdport_IORDYen,
  output logic [TWIDTH-1:0] PIO_cmdport_T1,
  output logic [TWIDTH-1:0] PIO_cmdport_T2,
  output logic [TWIDTH-1:0] PIO_cmdport_T4,
  output logic [TWIDTH-1:0] PIO_cmdport_Teoc,
  output logic              PIOreq,
  input  logic              PIOack,
  output logic [3:0]        PIOa,
  output logic [15:0]       PIOd,
  input  logic [15:0]       PIOq,
  output logic              PIOwe
);

  if (TWIDTH != 8) begin : g_twidth_check
    $error("ocidec1_wb_slave: TWIDTH must be 8 to match the PCTR byte layout");
  end

  localparam logic [31:0] PCTR_RST = {8'(PIO_mode0_Teoc), 8'(PIO_mode0_T4),
                                      8'(PIO_mode0_T2),   8'(PIO_mode0_T1)};

  pio_state_e  state_q, state_d;
  logic        ctrl_rst_q, ctrl_rst_d, ctrl_ideen_q, ctrl_ideen_d;
  logic        ctrl_iordy_q, ctrl_iordy_d, ctrl_ien_q, ctrl_ien_d;
  logic        stat_irq_q, stat_irq_d, irq_q, inta_q, inta_d;
  logic [31:0] pctr_q, pctr_d, dat_q, dat_d, rdata;
  logic        ack_q, ack_d, err_q, err_d;
  logic        pioreq_q, pioreq_d, piowe_q, piowe_d;
  logic [3:0]  pioa_q, pioa_d;
  logic [15:0] piod_q, piod_d;

  logic       acc, ata, int_acc;
  logic [3:0] reg_adr;

  assign acc     = wb.wb_cyc_i & wb.wb_stb_i;
  assign ata     = wb.wb_adr_i[4];
  assign reg_adr = wb.wb_adr_i[3:0];
  // Internal registers only answer from IDLE; ack_q forces the re-arm gap between acks.
  assign int_acc = acc & ~ata & (state_q == ST_IDLE) & ~ack_q;

  always_comb begin
    rdata = '0;
    case (reg_adr)
      ADR_CTRL: begin
        rdata[CTRL_RST]     = ctrl_rst_q;
        rdata[CTRL_IDEEN]   = ctrl_ideen_q;
        rdata[CTRL_IORDYEN] = ctrl_iordy_q;
        rdata[CTRL_IEN]     = ctrl_ien_q;
      end
      ADR_STAT: begin
        rdata[31:24]     = REVISION;
        rdata[STAT_BUSY] = (state_q != ST_IDLE);
        rdata[STAT_IRQ]  = stat_irq_q;
      end
      ADR_PCTR: rdata = pctr_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ctrl_rst_d   = ctrl_rst_q;
    ctrl_ideen_d = ctrl_ideen_q;
    ctrl_iordy_d = ctrl_iordy_q;
    ctrl_ien_d   = ctrl_ien_q;
    stat_irq_d   = stat_irq_q;
    pctr_d       = pctr_q;
    dat_d        = dat_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    pioreq_d     = pioreq_q;
    pioa_d       = pioa_q;
    piod_d       = piod_q;
    piowe_d      = piowe_q;
    inta_d       = stat_irq_q & ctrl_ien_q;

    if (int_acc) begin
      ack_d = 1'b1;
      dat_d = rdata;
      if (wb.wb_we_i) begin
        case (reg_adr)
          ADR_CTRL: if (wb.wb_sel_i[0]) begin
            ctrl_rst_d   = wb.wb_dat_i[CTRL_RST];
            ctrl_ideen_d = wb.wb_dat_i[CTRL_IDEEN];
            ctrl_iordy_d = wb.wb_dat_i[CTRL_IORDYEN];
            ctrl_ien_d   = wb.wb_dat_i[CTRL_IEN];
          end
          ADR_STAT: if (wb.wb_sel_i[0] && wb.wb_dat_i[STAT_IRQ]) stat_irq_d = 1'b0;
          ADR_PCTR: for (int unsigned b = 0; b < 4; b++)
            if (wb.wb_sel_i[b]) pctr_d[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
          default: ;
        endcase
      end
    end

    // Evaluated after the W1C so a coincident new interrupt edge is not lost.
    if (irq && !irq_q) stat_irq_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (acc && ata) begin
          if (wb.wb_sel_i[1:0] == 2'b11) begin
            pioa_d   = reg_adr;
            piod_d   = wb.wb_dat_i[15:0];
            piowe_d  = wb.wb_we_i;
            pioreq_d = 1'b1;
            state_d  = ST_PIO;
          end else if (!err_q) begin
            err_d = 1'b1;
          end
        end
      end
      ST_PIO: begin
        if (PIOack) begin
          pioreq_d = 1'b0;
          if (acc) begin
            ack_d = 1'b1;
            dat_d = {16'h0000, PIOq};
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctrl_rst_q   <= 1'b1;
      ctrl_ideen_q <= 1'b0;
      ctrl_iordy_q <= 1'b0;
      ctrl_ien_q   <= 1'b0;
      stat_irq_q   <= 1'b0;
      irq_q        <= 1'b0;
      inta_q       <= 1'b0;
      pctr_q       <= PCTR_RST;
      dat_q        <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      pioreq_q     <= 1'b0;
      pioa_q       <= '0;
      piod_q       <= '0;
      piowe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_rst_q   <= ctrl_rst_d;
      ctrl_ideen_q <= ctrl_ideen_d;
      ctrl_iordy_q <= ctrl_iordy_d;
      ctrl_ien_q   <= ctrl_ien_d;
      stat_irq_q   <= stat_irq_d;
      irq_q        <= irq;
      inta_q       <= inta_d;
      pctr_q       <= pctr_d;
      dat_q        <= dat_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      pioreq_q     <= pioreq_d;
      pioa_q       <= pioa_d;
      piod_q       <= piod_d;
      piowe_q      <= piowe_d;
    end
  end

  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_err_o  = err_q;
  assign wb.wb_inta_o = inta_q;

  assign IDEctrl_rst         = ctrl_rst_q;
  assign IDEctrl_IDEen       = ctrl_ideen_q;
  assign PIO_cmdport_IORDYen = ctrl_iordy_q;
  assign PIO_cmdport_T1      = pctr_q[0  +: TWIDTH];
  assign PIO_cmdport_T2      = pctr_q[8  +: TWIDTH];
  assign PIO_cmdport_T4      = pctr_q[16 +: TWIDTH];
  assign PIO_cmdport_Teoc    = pctr_q[24 +: TWIDTH];

  assign PIOreq = pioreq_q;
  assign PIOa   = pioa_q;
  assign PIOd   = piod_q;
  assign PIOwe  = piowe_q;

endmodule

// File: tb/tb_ocidec1_wb_slave.sv
// Directed bench for ocidec1_wb_slave with a behavioural PIO transfer-controller responder.
module tb_ocidec1_wb_slave;

  logic        clk, rst, irq;
  logic        IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen;
  logic [7:0]  T1, T2, T4, Teoc;
  logic        PIOreq, PIOack, PIOwe;
  logic [3:0]  PIOa;
  logic [15:0] PIOd, PIOq;

  ocidec1_wb_slave_if wb ();

  ocidec1_wb_slave dut (
    .clk                 (clk),
    .rst                 (rst),
    .wb                  (wb),
    .irq                 (irq),
    .IDEctrl_rst         (IDEctrl_rst),
    .IDEctrl_IDEen       (IDEctrl_IDEen),
    .PIO_cmdport_IORDYen (PIO_cmdport_IORDYen),
    .PIO_cmdport_T1      (T1),
    .PIO_cmdport_T2      (T2),
    .PIO_cmdport_T4      (T4),
    .PIO_cmdport_Teoc    (Teoc),
    .PIOreq              (PIOreq),
    .PIOack              (PIOack),
    .PIOa                (PIOa),
    .PIOd                (PIOd),
    .PIOq                (PIOq),
    .PIOwe               (PIOwe)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  // PIO responder state
  int          pio_delay = 4;
  logic [15:0] pio_q_val = 16'h0000;
  int          req_n = 0, held_n = 0, ack_cyc = 0, done_cnt = 0;
  logic [3:0]  cap_a;
  logic [15:0] cap_d;
  logic        cap_we, stable, req_low_after;
  int          last_ack_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PIOack = 1'b0;
    PIOq   = '0;
    stable = 1'b1;
    req_low_after = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        PIOack = 1'b0;
        req_n  = 0;
      end else if (PIOack) begin
        PIOack        = 1'b0;
        req_low_after = !PIOreq;
        done_cnt++;
        req_n = 0;
      end else if (PIOreq) begin
        if (req_n == 0) begin
          cap_a = PIOa; cap_d = PIOd; cap_we = PIOwe; stable = 1'b1;
        end else if (PIOa !== cap_a || PIOd !== cap_d || PIOwe !== cap_we) begin
          stable = 1'b0;
        end
        req_n++;
        held_n = req_n;
        if (req_n == pio_delay) begin
          PIOack  = 1'b1;
          PIOq    = pio_q_val;
          ack_cyc = cyc_cnt;
        end
      end else begin
        req_n = 0;
      end
    end
  end

  task automatic bus_idle();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdat,
                     output logic ack, output logic err);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    ack = 1'b0; err = 1'b0; rdat = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o || wb.wb_err_o) begin
        ack = wb.wb_ack_o; err = wb.wb_err_o; rdat = wb.wb_dat_o;
        last_ack_cyc = cyc_cnt;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ak, er;
    rst = 1'b1; irq = 1'b0; bus_idle();
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (wb.wb_ack_o !== 1'b0 || wb.wb_err_o !== 1'b0 || wb.wb_inta_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_bus_outs: ack/err/inta=%b%b%b want 000", wb.wb_ack_o, wb.wb_err_o, wb.wb_inta_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_dat_o: got %h want 00000000", wb.wb_dat_o); end
    n_checks++; if ({PIOreq, PIOa, PIOd, PIOwe} !== 22'h0) begin
      n_errors++; $display("FAIL reset_pio_outs: req=%b a=%h d=%h we=%b want all 0", PIOreq, PIOa, PIOd, PIOwe); end
    n_checks++; if ({IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen} !== 3'b100) begin
      n_errors++; $display("FAIL reset_ctrl_outs: got %b want 100", {IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen}); end
    bus(1'b0, 5'h00, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0000_0001) begin
      n_errors++; $display("FAIL reset_ctrl_read: ack=%b got %h want 00000001", ak, rd); end
    bus(1'b0, 5'h01, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0100_0000) begin
      n_errors++; $display("FAIL reset_stat_read: ack=%b got %h want 01000000", ak, rd); end
    bus(1'b0, 5'h02, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h1702_1C06) begin
      n_errors++; $display("FAIL reset_pctr_read: ack=%b got %h want 17021c06", ak, rd); end
    bus(1'b0, 5'h05, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0) begin
      n_errors++; $display("FAIL unmapped_read: ack=%b got %h want 00000000", ak, rd); end
  endtask

  task automatic test_pctr();
    logic [31:0] rd; logic ak, er;
    bus(1'b1, 5'h02, 32'hAABB_CCDD, 4'b0101, rd, ak, er);
    bus(1'b0, 5'h02, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h17BB_1CDD) begin
      n_errors++; $display("FAIL pctr_bytewrite: got %h want 17bb1cdd", rd); end
    n_checks++; if ({Teoc, T4, T2, T1} !== 32'h17BB_1CDD) begin
      n_errors++; $display("FAIL pctr_fields: got %h want 17bb1cdd", {Teoc, T4, T2, T1}); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic ak, er;
    bus(1'b1, 5'h00, 32'h0000_0002, 4'hF, rd, ak, er);
    bus(1'b1, 5'h00, 32'h0000_000F, 4'b1110, rd, ak, er);
    n_checks++; if ({IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen} !== 3'b010) begin
      n_errors++; $display("FAIL ctrl_outs: got %b want 010", {IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen}); end
    bus(1'b0, 5'h00, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h0000_0002) begin
      n_errors++; $display("FAIL ctrl_read: got %h want 00000002", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat; logic [31:0] first;
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 5'h00; wb.wb_sel_i = 4'hF;
    pat = '0; first = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = wb.wb_ack_o;
      if (i == 0) first = wb.wb_dat_o;
    end
    bus_idle();
    n_checks++; if (pat !== 4'b0101) begin
      n_errors++; $display("FAIL ack_rearm: pattern %b want 0101", pat); end
    n_checks++; if (first !== 32'h0000_0002) begin
      n_errors++; $display("FAIL held_read_data: got %h want 00000002", first); end
  endtask

  task automatic test_pio_write();
    logic [31:0] rd; logic ak, er;
    pio_delay = 40;
    bus(1'b1, 5'h17, 32'h0000_1234, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || er !== 1'b0) begin
      n_errors++; $display("FAIL pio_wr_ack: ack=%b err=%b want 1/0", ak, er); end
    n_checks++; if ({cap_a, cap_d, cap_we} !== {4'h7, 16'h1234, 1'b1}) begin
      n_errors++; $display("FAIL pio_wr_req: a=%h d=%h we=%b want 7 1234 1", cap_a, cap_d, cap_we); end
    n_checks++; if (stable !== 1'b1 || held_n != 40) begin
      n_errors++; $display("FAIL pio_wr_hold: stable=%b held=%0d want 1/40", stable, held_n); end
    n_checks++; if (last_ack_cyc - ack_cyc != 1) begin
      n_errors++; $display("FAIL pio_wr_ack_latency: %0d cycles want 1", last_ack_cyc - ack_cyc); end
    @(negedge clk);
    n_checks++; if (req_low_after !== 1'b1) begin
      n_errors++; $display("FAIL pio_wr_req_drop: req low after ack=%b want 1", req_low_after); end
  endtask

  task automatic test_pio_read();
    logic [31:0] rd; logic ak, er;
    pio_delay = 5; pio_q_val = 16'hBEEF;
    bus(1'b0, 5'h10, 32'hFFFF_FFFF, 4'b0011, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0000_BEEF) begin
      n_errors++; $display("FAIL pio_rd_data: ack=%b got %h want 0000beef", ak, rd); end
    n_checks++; if ({cap_a, cap_we} !== 5'h00 || held_n != 5) begin
      n_errors++; $display("FAIL pio_rd_req: a=%h we=%b held=%0d want 0 0 5", cap_a, cap_we, held_n); end
    bus(1'b0, 5'h01, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h0100_0000) begin
      n_errors++; $display("FAIL stat_not_busy: got %h want 01000000", rd); end
  endtask

  task automatic test_err();
    logic [31:0] rd; logic ak, er; int d0;
    d0 = done_cnt;
    bus(1'b1, 5'h12, 32'h0000_00AA, 4'b0001, rd, ak, er);
    n_checks++; if (er !== 1'b1 || ak !== 1'b0) begin
      n_errors++; $display("FAIL sel_err: err=%b ack=%b want 1/0", er, ak); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (PIOreq !== 1'b0 || done_cnt != d0 || wb.wb_err_o !== 1'b0) begin
      n_errors++; $display("FAIL sel_err_noreq: req=%b xfers=%0d err=%b want 0 %0d 0", PIOreq, done_cnt, wb.wb_err_o, d0); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic ak, er; logic seen, saw_ack; int d0;
    pio_delay = 20; d0 = done_cnt;
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 5'h13; wb.wb_dat_i = 32'h0000_5555; wb.wb_sel_i = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (PIOreq) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin
      n_errors++; $display("FAIL abort_req_start: PIOreq seen=%b want 1", seen); end
    repeat (5) @(posedge clk); #1;
    bus_idle();
    saw_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) saw_ack = 1'b1;
    end
    n_checks++; if (saw_ack !== 1'b0 || done_cnt != d0 + 1 || held_n != 20) begin
      n_errors++; $display("FAIL abort: ack=%b xfers=%0d held=%0d want 0 %0d 20", saw_ack, done_cnt, held_n, d0 + 1); end
    n_checks++; if (cap_d !== 16'h5555) begin
      n_errors++; $display("FAIL abort_data: got %h want 5555", cap_d); end
    bus(1'b0, 5'h00, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0000_0002) begin
      n_errors++; $display("FAIL abort_next_read: ack=%b got %h want 00000002", ak, rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic ak, er;
    bus(1'b1, 5'h00, 32'h0000_000A, 4'h1, rd, ak, er);
    @(posedge clk); #1 irq = 1'b1;
    repeat (3) @(posedge clk);
    bus(1'b0, 5'h01, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h0100_0001) begin
      n_errors++; $display("FAIL irq_set: got %h want 01000001", rd); end
    n_checks++; if (wb.wb_inta_o !== 1'b1) begin
      n_errors++; $display("FAIL inta_on: got %b want 1", wb.wb_inta_o); end
    irq = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 5'h01; wb.wb_dat_i = 32'h1; wb.wb_sel_i = 4'hF;
    irq = 1'b1;
    ak = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) begin ak = 1'b1; break; end
    end
    bus_idle();
    n_checks++; if (ak !== 1'b1) begin
      n_errors++; $display("FAIL irq_w1c_ack: got %b want 1", ak); end
    bus(1'b0, 5'h01, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h0100_0001) begin
      n_errors++; $display("FAIL irq_set_wins: got %h want 01000001", rd); end
    bus(1'b1, 5'h01, 32'h1, 4'hF, rd, ak, er);
    bus(1'b0, 5'h01, '0, 4'hF, rd, ak, er);
    n_checks++; if (rd !== 32'h0100_0000) begin
      n_errors++; $display("FAIL irq_w1c: got %h want 01000000", rd); end
    repeat (2) @(posedge clk); #1;
    n_checks++; if (wb.wb_inta_o !== 1'b0) begin
      n_errors++; $display("FAIL inta_off: got %b want 0", wb.wb_inta_o); end
  endtask

  task automatic test_reset_mid_pio();
    logic [31:0] rd; logic ak, er; logic seen;
    pio_delay = 1000;
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 5'h10; wb.wb_sel_i = 4'b0011;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (PIOreq) begin seen = 1'b1; break; end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (seen !== 1'b1 || PIOreq !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_pio: started=%b req=%b want 1/0", seen, PIOreq); end
    bus_idle();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    pio_delay = 3; pio_q_val = 16'h00A5;
    bus(1'b0, 5'h00, '0, 4'hF, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0000_0001) begin
      n_errors++; $display("FAIL post_reset_ctrl: ack=%b got %h want 00000001", ak, rd); end
    bus(1'b0, 5'h11, '0, 4'b0011, rd, ak, er);
    n_checks++; if (ak !== 1'b1 || rd !== 32'h0000_00A5 || cap_a !== 4'h1) begin
      n_errors++; $display("FAIL post_reset_pio: ack=%b got %h a=%h want 1 000000a5 1", ak, rd, cap_a); end
  endtask

  initial begin
    test_reset();
    test_pctr();
    test_ctrl();
    test_back_to_back();
    test_pio_write();
    test_pio_read();
    test_err();
    test_abort();
    test_irq();
    test_reset_mid_pio();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
